// File: rtl/proc_hazard_if.sv
`default_nettype none
// ============================================================================
// Module   : proc_hazard_if
// Purpose  : D-stage decode metadata in, hazard controls and stage valids out.
// Revision : 1.0
// ============================================================================
interface proc_hazard_if #(
  parameter int AW = 5
);
  // D-stage decode metadata and branch resolution from the datapath
  logic          val_D;
  logic [AW-1:0] rs1_D;
  logic [AW-1:0] rs2_D;
  logic          rs1_used_D;
  logic          rs2_used_D;
  logic [AW-1:0] rd_D;
  logic          wen_D;
  logic          is_load_D;
  logic          is_mul_D;
  logic          is_jump_D;
  logic          br_taken_X;

  // Pipeline controls back to the datapath
  logic          stall_F;
  logic          stall_D;
  logic          squash_F;
  logic          squash_D;
  logic          hold_X;
  logic [1:0]    op1_byp_sel_D;
  logic [1:0]    op2_byp_sel_D;
  logic          rf_wen_W;
  logic [AW-1:0] rf_waddr_W;
  logic          val_X;
  logic          val_M;
  logic          val_W;

  modport master (
    output val_D, rs1_D, rs2_D, rs1_used_D, rs2_used_D, rd_D, wen_D,
           is_load_D, is_mul_D, is_jump_D, br_taken_X,
    input  stall_F, stall_D, squash_F, squash_D, hold_X,
           op1_byp_sel_D, op2_byp_sel_D, rf_wen_W, rf_waddr_W,
           val_X, val_M, val_W
  );

  modport slave (
    input  val_D, rs1_D, rs2_D, rs1_used_D, rs2_used_D, rd_D, wen_D,
           is_load_D, is_mul_D, is_jump_D, br_taken_X,
    output stall_F, stall_D, squash_F, squash_D, hold_X,
           op1_byp_sel_D, op2_byp_sel_D, rf_wen_W, rf_waddr_W,
           val_X, val_M, val_W
  );
endinterface
`default_nettype wire

// File: rtl/proc_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : proc_hazard_unit
// Purpose  : X/M/W tracking, bypass selection, stall/squash and MUL hold.
// Revision : 1.0
// ============================================================================
module proc_hazard_unit #(
  parameter int NREGS   = 32,
  parameter int MUL_LAT = 1,
  parameter int BYP_EN  = 1
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  proc_hazard_if.slave hz
);
  localparam int AW = $clog2(NREGS);
  localparam logic [3:0] c_mul_init = 4'(MUL_LAT - 1);

  typedef struct packed {
    logic          val;
    logic [AW-1:0] rd;
    logic          wen;
    logic          is_load;
    logic          is_mul;
  } stage_t;

  stage_t     r_x;
  stage_t     r_m;
  stage_t     r_w;
  logic [3:0] r_mul_cnt;

  // x0 is hardwired, so a stage targeting it is never a producer
  function automatic logic writes(input stage_t s, input logic [AW-1:0] r);
    return s.val & s.wen & (s.rd == r) & (r != '0);
  endfunction

  logic w_rs1_x, w_rs1_m, w_rs1_w;
  logic w_rs2_x, w_rs2_m, w_rs2_w;

  assign w_rs1_x = hz.val_D & hz.rs1_used_D & writes(r_x, hz.rs1_D);
  assign w_rs1_m = hz.val_D & hz.rs1_used_D & writes(r_m, hz.rs1_D);
  assign w_rs1_w = hz.val_D & hz.rs1_used_D & writes(r_w, hz.rs1_D);
  assign w_rs2_x = hz.val_D & hz.rs2_used_D & writes(r_x, hz.rs2_D);
  assign w_rs2_m = hz.val_D & hz.rs2_used_D & writes(r_m, hz.rs2_D);
  assign w_rs2_w = hz.val_D & hz.rs2_used_D & writes(r_w, hz.rs2_D);

  logic [1:0] w_op1_sel;
  logic [1:0] w_op2_sel;
  logic       w_raw;

  generate
    if (BYP_EN != 0) begin : g_byp
      assign w_op1_sel = w_rs1_x ? 2'd1 : w_rs1_m ? 2'd2 : w_rs1_w ? 2'd3 : 2'd0;
      assign w_op2_sel = w_rs2_x ? 2'd1 : w_rs2_m ? 2'd2 : w_rs2_w ? 2'd3 : 2'd0;
      assign w_raw     = 1'b0;
    end else begin : g_nobyp
      assign w_op1_sel = 2'd0;
      assign w_op2_sel = 2'd0;
      assign w_raw     = w_rs1_x | w_rs1_m | w_rs1_w | w_rs2_x | w_rs2_m | w_rs2_w;
    end
  endgenerate

  logic w_load_use;
  logic w_hold;
  logic w_br;
  logic w_stall;
  logic w_squash_d;
  logic w_squash_f;
  logic w_adv_d;

  assign w_load_use = r_x.is_load & (w_rs1_x | w_rs2_x);
  assign w_hold     = (r_mul_cnt != 4'd0);
  assign w_br       = hz.br_taken_X;
  // A taken branch kills everything younger, so it overrides all stalls
  assign w_stall    = ~w_br & (w_hold | w_load_use | w_raw);
  // Load-use bubble is suppressed while X is held; it re-evaluates afterwards
  assign w_squash_d = w_br | (w_load_use & ~w_hold);
  assign w_squash_f = w_br | (hz.val_D & hz.is_jump_D & ~w_stall);
  assign w_adv_d    = hz.val_D & ~w_stall & ~w_squash_d;

  stage_t w_d_stage;
  assign w_d_stage = '{val: 1'b1, rd: hz.rd_D, wen: hz.wen_D,
                       is_load: hz.is_load_D, is_mul: hz.is_mul_D};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x       <= '0;
      r_m       <= '0;
      r_w       <= '0;
      r_mul_cnt <= 4'd0;
    end else begin
      r_w <= r_m;
      if (w_br) begin
        r_m       <= r_x;
        r_x       <= '0;
        r_mul_cnt <= 4'd0;
      end else if (w_hold) begin
        r_m       <= '0;
        r_mul_cnt <= r_mul_cnt - 4'd1;
      end else begin
        r_m       <= r_x;
        r_x       <= w_adv_d ? w_d_stage : '0;
        r_mul_cnt <= (w_adv_d & hz.is_mul_D) ? c_mul_init : 4'd0;
      end
    end
  end

  // D-dependent controls are forced low while reset is asserted
  assign hz.stall_F       = rst_n & w_stall;
  assign hz.stall_D       = rst_n & w_stall;
  assign hz.squash_F      = rst_n & w_squash_f;
  assign hz.squash_D      = rst_n & w_squash_d;
  assign hz.hold_X        = rst_n & w_hold & ~w_br;
  assign hz.op1_byp_sel_D = rst_n ? w_op1_sel : 2'd0;
  assign hz.op2_byp_sel_D = rst_n ? w_op2_sel : 2'd0;
  assign hz.rf_wen_W      = r_w.val & r_w.wen;
  assign hz.rf_waddr_W    = r_w.rd;
  assign hz.val_X         = r_x.val;
  assign hz.val_M         = r_m.val;
  assign hz.val_W         = r_w.val;

  // Class bits kept in every stage for observability; not all feed decisions
  logic w_unused;
  assign w_unused = ^{r_x.is_mul, r_m.is_load, r_m.is_mul, r_w.is_load, r_w.is_mul};

endmodule
`default_nettype wire

// File: tb/tb_proc_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_proc_hazard_unit
// Purpose  : Directed scoreboard bench for proc_hazard_unit (two configs).
// Revision : 1.0
// ============================================================================
module tb_proc_hazard_unit;
  localparam int AW = 5;
  localparam int XX = -1;
  localparam int DA = 0;   // MUL_LAT=4, bypassing
  localparam int DC = 1;   // MUL_LAT=1, no bypassing

  typedef int vec_t[12];
  typedef struct { string nm; int dut; vec_t f; } item_t;
  typedef struct { bit v; int rd; int r1; bit u1; int r2; bit u2;
                   bit wen; bit ld; bit mul; bit jmp; } instr_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  item_t sb_q[$];
  string fname[12] = '{"stall_F", "stall_D", "squash_F", "squash_D", "hold_X",
                       "op1_sel", "op2_sel", "rf_wen_W", "rf_waddr_W",
                       "val_X", "val_M", "val_W"};

  logic          d_val, d_u1, d_u2, d_wen, d_ld, d_mul, d_jmp, d_br;
  logic [AW-1:0] d_rs1, d_rs2, d_rd;

  proc_hazard_if #(.AW(AW)) hz_a ();
  proc_hazard_if #(.AW(AW)) hz_c ();

  assign hz_a.val_D = d_val;  assign hz_c.val_D = d_val;
  assign hz_a.rs1_D = d_rs1;  assign hz_c.rs1_D = d_rs1;
  assign hz_a.rs2_D = d_rs2;  assign hz_c.rs2_D = d_rs2;
  assign hz_a.rs1_used_D = d_u1;  assign hz_c.rs1_used_D = d_u1;
  assign hz_a.rs2_used_D = d_u2;  assign hz_c.rs2_used_D = d_u2;
  assign hz_a.rd_D = d_rd;    assign hz_c.rd_D = d_rd;
  assign hz_a.wen_D = d_wen;  assign hz_c.wen_D = d_wen;
  assign hz_a.is_load_D = d_ld;   assign hz_c.is_load_D = d_ld;
  assign hz_a.is_mul_D = d_mul;   assign hz_c.is_mul_D = d_mul;
  assign hz_a.is_jump_D = d_jmp;  assign hz_c.is_jump_D = d_jmp;
  assign hz_a.br_taken_X = d_br;  assign hz_c.br_taken_X = d_br;

  proc_hazard_unit #(.NREGS(32), .MUL_LAT(4), .BYP_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .hz(hz_a));
  proc_hazard_unit #(.NREGS(32), .MUL_LAT(1), .BYP_EN(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .hz(hz_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic instr_t nop();
    instr_t i = '{1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    return i;
  endfunction

  function automatic instr_t op(int rd, int r1, bit u1, int r2, bit u2,
                                bit wen, bit ld, bit mul, bit jmp);
    instr_t i = '{1'b1, rd, r1, u1, r2, u2, wen, ld, mul, jmp};
    return i;
  endfunction

  function automatic item_t ex(string nm, int d, int sf, int sd, int qf, int qd,
                               int hx, int o1, int o2, int we, int wa,
                               int vx, int vm, int vw);
    item_t it;
    it.nm = nm; it.dut = d;
    it.f[0] = sf; it.f[1] = sd; it.f[2] = qf;  it.f[3]  = qd;
    it.f[4] = hx; it.f[5] = o1; it.f[6] = o2;  it.f[7]  = we;
    it.f[8] = wa; it.f[9] = vx; it.f[10] = vm; it.f[11] = vw;
    return it;
  endfunction

  function automatic vec_t sample(int d);
    vec_t a;
    if (d == DA) begin
      a[0] = int'(hz_a.stall_F);  a[1] = int'(hz_a.stall_D);
      a[2] = int'(hz_a.squash_F); a[3] = int'(hz_a.squash_D);
      a[4] = int'(hz_a.hold_X);   a[5] = int'(hz_a.op1_byp_sel_D);
      a[6] = int'(hz_a.op2_byp_sel_D); a[7] = int'(hz_a.rf_wen_W);
      a[8] = int'(hz_a.rf_waddr_W); a[9] = int'(hz_a.val_X);
      a[10] = int'(hz_a.val_M);   a[11] = int'(hz_a.val_W);
    end else begin
      a[0] = int'(hz_c.stall_F);  a[1] = int'(hz_c.stall_D);
      a[2] = int'(hz_c.squash_F); a[3] = int'(hz_c.squash_D);
      a[4] = int'(hz_c.hold_X);   a[5] = int'(hz_c.op1_byp_sel_D);
      a[6] = int'(hz_c.op2_byp_sel_D); a[7] = int'(hz_c.rf_wen_W);
      a[8] = int'(hz_c.rf_waddr_W); a[9] = int'(hz_c.val_X);
      a[10] = int'(hz_c.val_M);   a[11] = int'(hz_c.val_W);
    end
    return a;
  endfunction

  // One clock of stimulus; its expected response goes to the scoreboard
  task automatic cyc(input instr_t i, input bit br, input bit rst, input item_t e);
    @(posedge clk);
    #1;
    rst_n = rst;
    d_val = i.v;  d_rd = AW'(i.rd); d_rs1 = AW'(i.r1); d_u1 = i.u1;
    d_rs2 = AW'(i.r2); d_u2 = i.u2; d_wen = i.wen; d_ld = i.ld;
    d_mul = i.mul; d_jmp = i.jmp; d_br = br;
    sb_q.push_back(e);
  endtask

  task automatic rst_cycle(input int d);
    cyc(nop(), 1'b0, 1'b0, ex("reset", d, 0,0,0,0,0, 0,0, 0,0, 0,0,0));
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response
  initial begin
    item_t it;
    vec_t  act;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        it  = sb_q.pop_front();
        act = sample(it.dut);
        for (int k = 0; k < 12; k++) begin
          if (it.f[k] != XX) begin
            total++;
            if (act[k] != it.f[k]) begin
              bad++;
              $display("FAIL %s %s: got %0d want %0d", it.nm, fname[k], act[k], it.f[k]);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    total++;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    total = 0; bad = 0; rst_n = 1'b0;
    d_val = 0; d_rd = '0; d_rs1 = '0; d_u1 = 0; d_rs2 = '0; d_u2 = 0;
    d_wen = 0; d_ld = 0; d_mul = 0; d_jmp = 0; d_br = 0;

    rst_cycle(DA);
    rst_cycle(DC);

    // ADDI x1 ; ADD x2,x1,x1 with full bypassing
    cyc(op(1,0,1,0,0,1,0,0,0), 0, 1, ex("byp_addi", DA, 0,0,0,0,0, 0,0, 0,0, 0,0,0));
    cyc(op(2,1,1,1,1,1,0,0,0), 0, 1, ex("byp_add",  DA, 0,0,0,0,0, 1,1, 0,0, 1,0,0));
    cyc(nop(), 0, 1, ex("byp_p2", DA, 0,0,0,0,0, 0,0, 0,0, 1,1,0));
    cyc(nop(), 0, 1, ex("byp_p3", DA, 0,0,0,0,0, 0,0, 1,1, 0,1,1));
    cyc(nop(), 0, 1, ex("byp_wb", DA, 0,0,0,0,0, 0,0, 1,2, 0,0,1));

    // LW x3 ; ADD x4,x3,x0 load-use
    rst_cycle(DA);
    cyc(op(3,0,1,0,0,1,1,0,0), 0, 1, ex("lu_lw",    DA, 0,0,0,0,0, 0,0, 0,0, 0,0,0));
    cyc(op(4,3,1,0,1,1,0,0,0), 0, 1, ex("lu_stall", DA, 1,1,0,1,0, XX,0, 0,0, 1,0,0));
    cyc(op(4,3,1,0,1,1,0,0,0), 0, 1, ex("lu_byp",   DA, 0,0,0,0,0, 2,0, 0,0, 0,1,0));
    cyc(nop(), 0, 1, ex("lu_wb", DA, 0,0,0,0,0, 0,0, 1,3, 1,0,1));

    // MUL x5 ; ADD x6,x5,x5 with MUL_LAT=4
    rst_cycle(DA);
    cyc(op(5,0,1,0,1,1,0,1,0), 0, 1, ex("mul_in",    DA, 0,0,0,0,0, 0,0, 0,0, 0,0,0));
    cyc(op(6,5,1,5,1,1,0,0,0), 0, 1, ex("mul_hold1", DA, 1,1,0,0,1, 1,1, 0,0, 1,0,0));
    cyc(op(6,5,1,5,1,1,0,0,0), 0, 1, ex("mul_hold2", DA, 1,1,0,0,1, 1,1, 0,0, 1,0,0));
    cyc(op(6,5,1,5,1,1,0,0,0), 0, 1, ex("mul_hold3", DA, 1,1,0,0,1, 1,1, 0,0, 1,0,0));
    cyc(op(6,5,1,5,1,1,0,0,0), 0, 1, ex("mul_done",  DA, 0,0,0,0,0, 1,1, 0,0, 1,0,0));
    cyc(nop(), 0, 1, ex("mul_adv", DA, 0,0,0,0,0, 0,0, 0,0, 1,1,0));

    // Taken branch overrides a load-use stall
    rst_cycle(DA);
    cyc(op(3,0,1,0,0,1,1,0,0), 0, 1, ex("br_lw",     DA, 0,0,0,0,0, 0,0, 0,0, 0,0,0));
    cyc(op(4,3,1,0,1,1,0,0,0), 1, 1, ex("br_squash", DA, 0,0,1,1,0, XX,0, 0,0, 1,0,0));
    cyc(nop(), 0, 1, ex("br_after", DA, 0,0,0,0,0, 0,0, 0,0, 0,1,0));

    // Taken branch clears an active MUL hold
    rst_cycle(DA);
    cyc(op(5,0,1,0,1,1,0,1,0), 0, 1, ex("brh_mul", DA, 0,0,0,0,0, 0,0, 0,0, 0,0,0));
    cyc(op(6,5,1,5,1,1,0,0,0), 1, 1, ex("brh_br",  DA, 0,0,1,1,0, 1,1, 0,0, 1,0,0));
    cyc(nop(), 0, 1, ex("brh_after", DA, 0,0,0,0,0, 0,0, 0,0, 0,1,0));

    // JAL squashes F; a stalled JR waits, then squashes
    rst_cycle(DA);
    cyc(op(1,0,0,0,0,1,0,0,1), 0, 1, ex("jal",      DA, 0,0,1,0,0, 0,0, 0,0, 0,0,0));
    cyc(op(3,0,1,0,0,1,1,0,0), 0, 1, ex("j_lw",     DA, 0,0,0,0,0, 0,0, 0,0, 1,0,0));
    cyc(op(0,3,1,0,0,0,0,0,1), 0, 1, ex("jr_stall", DA, 1,1,0,1,0, XX,0, 0,0, 1,1,0));
    cyc(op(0,3,1,0,0,0,0,0,1), 0, 1, ex("jr_go",    DA, 0,0,1,0,0, 2,0, 1,1, 0,1,1));

    // No bypassing: ADDI x7 ; ADD x8,x7,x0 then MUL with MUL_LAT=1
    rst_cycle(DC);
    cyc(op(7,0,1,0,0,1,0,0,0), 0, 1, ex("nb_addi", DC, 0,0,0,0,0, 0,0, 0,0, 0,0,0));
    cyc(op(8,7,1,0,1,1,0,0,0), 0, 1, ex("nb_st1",  DC, 1,1,0,0,0, 0,0, 0,0, 1,0,0));
    cyc(op(8,7,1,0,1,1,0,0,0), 0, 1, ex("nb_st2",  DC, 1,1,0,0,0, 0,0, 0,0, 0,1,0));
    cyc(op(8,7,1,0,1,1,0,0,0), 0, 1, ex("nb_st3",  DC, 1,1,0,0,0, 0,0, 1,7, 0,0,1));
    cyc(op(8,7,1,0,1,1,0,0,0), 0, 1, ex("nb_go",   DC, 0,0,0,0,0, 0,0, 0,0, 0,0,0));
    cyc(nop(), 0, 1, ex("nb_adv", DC, 0,0,0,0,0, 0,0, 0,0, 1,0,0));
    cyc(op(5,0,1,0,1,1,0,1,0), 0, 1, ex("c_mul",    DC, 0,0,0,0,0, 0,0, 0,0, 0,1,0));
    cyc(nop(), 0, 1, ex("c_mul_nohold", DC, 0,0,0,0,0, 0,0, 1,8, 1,0,1));

    // Reset asserted during a MUL hold
    rst_cycle(DA);
    cyc(op(5,0,1,0,1,1,0,1,0), 0, 1, ex("rh_mul",  DA, 0,0,0,0,0, 0,0, 0,0, 0,0,0));
    cyc(op(6,5,1,5,1,1,0,0,0), 0, 1, ex("rh_hold", DA, 1,1,0,0,1, 1,1, 0,0, 1,0,0));
    cyc(op(6,5,1,5,1,1,0,0,1), 1, 0, ex("rh_rst",  DA, 0,0,0,0,0, 0,0, 0,0, 0,0,0));
    cyc(op(6,5,1,5,1,1,0,0,0), 0, 1, ex("rh_rel",  DA, 0,0,0,0,0, 0,0, 0,0, 0,0,0));
    cyc(nop(), 0, 1, ex("rh_after", DA, 0,0,0,0,0, 0,0, 0,0, 1,0,0));

    repeat (2) @(posedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/proc_hazard_unit.md
# proc_hazard_unit

Parametrised hazard and pipeline-tracking controller for the five-stage TinyRV1 processor (F, D, X, M, W). It tracks valid bits and destination-register metadata for the X, M and W stages and resolves hazards from that state. Outputs are bypass selects, stall and squash signals, and the W-stage register-file write controls. It extends the fixed squash-only control with register bypassing, load-use and RAW stalling, and a configurable multi-cycle multiplier hold in X.

## Interface
- NREGS, 32: architectural register count; AW = $clog2(NREGS) address width
- MUL_LAT, 1: cycles a MUL occupies X (1..15)
- BYP_EN, 1: 1 = full bypassing; 0 = stall on any RAW until the producer has left W
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- val_D  in  1  D holds a valid instruction
- rs1_D, rs2_D  in  AW  source addresses; rs1_used_D, rs2_used_D  in  1  source is read
- rd_D  in  AW  destination; wen_D  in  1  instruction writes rd
- is_load_D, is_mul_D, is_jump_D  in  1  D instruction class (jump = JAL/JR)
- br_taken_X  in  1  valid BNE in X resolved not-equal
- stall_F, stall_D  out  1  hold PC / FD register
- squash_F  out  1  kill instruction entering D
- squash_D  out  1  insert bubble into X
- hold_X  out  1  MUL busy; X register held, bubble to M
- op1_byp_sel_D, op2_byp_sel_D  out  2  0 RF, 1 X, 2 M, 3 W
- rf_wen_W  out  1; rf_waddr_W  out  AW
- val_X, val_M, val_W  out  1  stage valid bits

## Operation
- Per-stage tracking registers for X, M and W: val, rd, wen, is_load, is_mul. They advance on every cycle unless a hold applies.
- A stage writes reg r when val and wen are set and r != 0. Register 0 never causes a hazard or a bypass.
- Bypass (BYP_EN=1): for each used source, select the youngest writing stage with a matching rd, in priority order X > M > W. Otherwise select 0.
- Load-use: a used source matches the rd of a load in X → stall_F = stall_D = 1 and squash_D = 1 (bubble into X) for one cycle.
- BYP_EN=0: any used source matches a writing stage among X/M/W → stall. Selects are forced to 0.
- MUL hold: when a MUL enters X, a down-counter loads MUL_LAT-1. While the counter is nonzero:
  - hold_X = 1;
  - F, D and X are held;
  - M receives a bubble;
  - the counter decrements.
  - MUL_LAT=1 → no hold.
- Jump: a valid jump in D that is not stalled → squash_F = 1. The jump's redirect is applied by the datapath. A stalled jump does not squash until it advances.
- Branch: br_taken_X → squash_D = 1 and squash_F = 1.
  - Overrides every stall: stall_F = stall_D = 0, and hold_X is cleared along with its counter.
  - Branch squash beats load-use and jump.
- Hazard checks are qualified by val_D; an invalid D never stalls.
- W-stage writes: rf_wen_W = val_W & wen_W; rf_waddr_W = rd_W.

## Timing
- All hazard outputs are combinational from the current stage state and D inputs. Tracking registers update on posedge clk.
- Reset (rst = 0, asynchronous): all val bits 0, MUL counter 0, stored rd/wen/is_* 0. Outputs during reset:
  - stalls and squashes 0;
  - selects 0;
  - rf_wen_W 0; rf_waddr_W 0.
- Reset deasserted mid-MUL: the counter is lost and no residual hold occurs.
- Load-use stall latency: exactly 1 cycle. The following cycle selects X→M bypass from M (sel 2).
- MUL in X: D stalls MUL_LAT-1 cycles. A dependent instruction then bypasses from X (sel 1) in the cycle the MUL leaves hold.
- Simultaneous load-use plus MUL hold: hold dominates, and the load-use check re-evaluates after the hold.
- A bubble occupies its slot with val = 0 and never bypasses.

## Test plan
- ADDI x1 then ADD x2,x1,x1 back-to-back, BYP_EN=1 → no stall; the ADD sees op1/op2 sel = 1; three cycles later rf_wen_W=1, rf_waddr_W=2.
- LW x3 then ADD x4,x3,x0 → one cycle with stall_D=1 and squash_D=1; the next cycle op1 sel = 2; op2 sel = 0 (x0).
- MUL_LAT=4: MUL x5 then ADD x6,x5,x5 → hold_X=1 for 3 cycles with stall_D=1; then sel = 1; val_M=0 during the hold.
- BNE in X with br_taken_X=1 while D has a load-use stall → squash_F=squash_D=1, stall_D=0; next cycle val_X=0.
- BYP_EN=0: ADDI x7 then ADD x8,x7,x0 → stall_D=1 for 3 cycles (producer in X, M, W); then proceed with sel 0.
- Assert rst low during a MUL hold → all outputs 0 immediately. After release, val_X=0 and no hold_X.
